hazard_forward_unit: RTL

Parametrised successor to the EX-stage forwarding selector for the pipelined CPU. Combines EX operand forwarding (MEM/WB sources), ID-stage branch-compare forwarding, and a sequential load-use stall controller with configurable bubble count. It also drives the branch flush controls and a saturating stall-cycle performance counter. Sits beside the ID/EX pipeline registers and drives the PC/IF-ID write enables, the flush signals and the operand muxes.

---
 rtl/hazard_forward_unit_if.sv | 47 ++++
 rtl/hazard_forward_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit_if.sv
// Bus bundle between the hazard/forwarding unit and the pipeline it controls.
// The slave modport is the unit's view; master is the pipeline/driver view.
interface hazard_forward_unit_if #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
);
   logic [ADDR_W-1:0] ID_RS_addr_i;
   logic [ADDR_W-1:0] ID_RT_addr_i;
   logic              ID_uses_RT_i;
   logic [ADDR_W-1:0] EX_RS_addr_i;
   logic [ADDR_W-1:0] EX_RT_addr_i;
   logic [ADDR_W-1:0] EX_write_addr_i;
   logic              EX_RegWrite_i;
   logic              EX_MemRead_i;
   logic [ADDR_W-1:0] MEM_write_addr_i;
   logic              MEM_RegWrite_i;
   logic [ADDR_W-1:0] WB_write_addr_i;
   logic              WB_RegWrite_i;
   logic              branch_taken_i;
   logic [1:0]        RS_select_o;
   logic [1:0]        RT_select_o;
   logic              ID_RS_fwd_o;
   logic              ID_RT_fwd_o;
   logic              PC_write_o;
   logic              IFID_write_o;
   logic              IDEX_flush_o;
   logic              IFID_flush_o;
   logic [CNT_W-1:0]  stall_cycles_o;

   modport slave (
      input  ID_RS_addr_i, ID_RT_addr_i, ID_uses_RT_i,
      input  EX_RS_addr_i, EX_RT_addr_i, EX_write_addr_i, EX_RegWrite_i, EX_MemRead_i,
      input  MEM_write_addr_i, MEM_RegWrite_i, WB_write_addr_i, WB_RegWrite_i,
      input  branch_taken_i,
      output RS_select_o, RT_select_o, ID_RS_fwd_o, ID_RT_fwd_o,
      output PC_write_o, IFID_write_o, IDEX_flush_o, IFID_flush_o, stall_cycles_o
   );

   modport master (
      output ID_RS_addr_i, ID_RT_addr_i, ID_uses_RT_i,
      output EX_RS_addr_i, EX_RT_addr_i, EX_write_addr_i, EX_RegWrite_i, EX_MemRead_i,
      output MEM_write_addr_i, MEM_RegWrite_i, WB_write_addr_i, WB_RegWrite_i,
      output branch_taken_i,
      input  RS_select_o, RT_select_o, ID_RS_fwd_o, ID_RT_fwd_o,
      input  PC_write_o, IFID_write_o, IDEX_flush_o, IFID_flush_o, stall_cycles_o
   );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX/ID operand forwarding, load-use stall sequencer with LOAD_BUBBLES bubbles,
// taken-branch flush control and a saturating stall-cycle counter.
module hazard_forward_unit #(
   parameter int ADDR_W       = 5,
   parameter int LOAD_BUBBLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   hazard_forward_unit_if.slave  bus
);

   typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

   localparam logic [2:0]       BUB_RELOAD = 3'(LOAD_BUBBLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_q, state_d;
   logic [2:0]       bub_cnt_q, bub_cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic       hazard_s;
   logic       stall_s;
   logic [1:0] rs_sel_s, rt_sel_s;
   logic       id_rs_fwd_s, id_rt_fwd_s;
   logic       pc_write_s, ifid_write_s, idex_flush_s, ifid_flush_s;

   // Register 0 is hardwired, so a write to it is never a forwarding source.
   function automatic logic src_match(input logic we, input logic [ADDR_W-1:0] dst,
                                      input logic [ADDR_W-1:0] src);
      return we && (dst != {ADDR_W{1'b0}}) && (dst == src);
   endfunction

   function automatic logic [1:0] ex_select(input logic [ADDR_W-1:0] src,
                                            input logic mem_we, input logic [ADDR_W-1:0] mem_dst,
                                            input logic wb_we,  input logic [ADDR_W-1:0] wb_dst);
      logic [1:0] sel;
      if (src_match(mem_we, mem_dst, src)) begin
         sel = 2'd1;
      end else if (src_match(wb_we, wb_dst, src)) begin
         sel = 2'd2;
      end else begin
         sel = 2'd0;
      end
      return sel;
   endfunction

   // Forwarding selects and load-use hazard detection.
   always_comb begin
      rs_sel_s    = 2'd0;
      rt_sel_s    = 2'd0;
      id_rs_fwd_s = 1'b0;
      id_rt_fwd_s = 1'b0;
      if (rst_i) begin
         rs_sel_s    = 2'd0;
         rt_sel_s    = 2'd0;
         id_rs_fwd_s = 1'b0;
         id_rt_fwd_s = 1'b0;
      end else begin
         rs_sel_s    = ex_select(bus.EX_RS_addr_i, bus.MEM_RegWrite_i, bus.MEM_write_addr_i,
                                 bus.WB_RegWrite_i, bus.WB_write_addr_i);
         rt_sel_s    = ex_select(bus.EX_RT_addr_i, bus.MEM_RegWrite_i, bus.MEM_write_addr_i,
                                 bus.WB_RegWrite_i, bus.WB_write_addr_i);
         id_rs_fwd_s = src_match(bus.MEM_RegWrite_i, bus.MEM_write_addr_i, bus.ID_RS_addr_i);
         id_rt_fwd_s = bus.ID_uses_RT_i &&
                       src_match(bus.MEM_RegWrite_i, bus.MEM_write_addr_i, bus.ID_RT_addr_i);
      end
      hazard_s = bus.EX_MemRead_i &&
                 (src_match(bus.EX_RegWrite_i, bus.EX_write_addr_i, bus.ID_RS_addr_i) ||
                  (bus.ID_uses_RT_i &&
                   src_match(bus.EX_RegWrite_i, bus.EX_write_addr_i, bus.ID_RT_addr_i)));
   end

   // Stall sequencer next state; a taken branch squashes the stalled instruction.
   always_comb begin
      stall_s        = 1'b0;
      state_d        = state_q;
      bub_cnt_d      = bub_cnt_q;
      stall_cycles_d = stall_cycles_q;
      if (bus.branch_taken_i) begin
         state_d   = RUN;
         bub_cnt_d = 3'd0;
      end else begin
         case (state_q)
            RUN: begin
               if (hazard_s) begin
                  stall_s = 1'b1;
                  if (LOAD_BUBBLES > 1) begin
                     state_d   = STALL;
                     bub_cnt_d = BUB_RELOAD;
                  end else begin
                     state_d   = RUN;
                     bub_cnt_d = 3'd0;
                  end
               end else begin
                  state_d   = RUN;
                  bub_cnt_d = 3'd0;
               end
            end
            STALL: begin
               stall_s = 1'b1;
               if (bub_cnt_q == 3'd1) begin
                  state_d   = RUN;
                  bub_cnt_d = 3'd0;
               end else begin
                  bub_cnt_d = bub_cnt_q - 3'd1;
               end
            end
            default: begin
               state_d   = RUN;
               bub_cnt_d = 3'd0;
            end
         endcase
      end
      if (stall_s && (stall_cycles_q != CNT_MAX)) begin
         stall_cycles_d = stall_cycles_q + CNT_ONE;
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
   end

   // Pipeline write-enable and flush controls.
   always_comb begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      idex_flush_s = 1'b1;
      ifid_flush_s = 1'b1;
      if (rst_i) begin
         pc_write_s   = 1'b0;
         ifid_write_s = 1'b0;
         idex_flush_s = 1'b1;
         ifid_flush_s = 1'b1;
      end else if (bus.branch_taken_i) begin
         pc_write_s   = 1'b1;
         ifid_write_s = 1'b1;
         idex_flush_s = 1'b1;
         ifid_flush_s = 1'b1;
      end else begin
         pc_write_s   = !stall_s;
         ifid_write_s = !stall_s;
         idex_flush_s = stall_s;
         ifid_flush_s = 1'b0;
      end
   end

   // Sequencer state and stall counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= RUN;
         bub_cnt_q      <= 3'd0;
         stall_cycles_q <= {CNT_W{1'b0}};
      end else begin
         state_q        <= state_d;
         bub_cnt_q      <= bub_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign bus.RS_select_o    = rs_sel_s;
   assign bus.RT_select_o    = rt_sel_s;
   assign bus.ID_RS_fwd_o    = id_rs_fwd_s;
   assign bus.ID_RT_fwd_o    = id_rt_fwd_s;
   assign bus.PC_write_o     = pc_write_s;
   assign bus.IFID_write_o   = ifid_write_s;
   assign bus.IDEX_flush_o   = idex_flush_s;
   assign bus.IFID_flush_o   = ifid_flush_s;
   assign bus.stall_cycles_o = stall_cycles_q;

endmodule
